// File: rtl/dm_pkg.sv
// dm_pkg: FSM state encoding and status codes for the data-memory port controller
package dm_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
  localparam logic [1:0] ST_READY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
  localparam logic [1:0] ST_ERR   = 2'b11;
endpackage

// File: rtl/dm_sram.sv
// dm_sram: single-port-style data array, synchronous write, registered read, no reset
//   clock        rising-edge clock
//   we/waddr/wdata  write strobe, word address, data
//   re/raddr     read strobe and word address; rdata holds the last read word
module dm_sram #(
  parameter int DATA_W = 8,
  parameter int MEM_AW = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [MEM_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**MEM_AW];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dm_port_ctrl.sv
// dm_port_ctrl: data-memory port controller serving the core and a host preload/readback port
//   clock, rst_r                      clock, async active-low reset
//   dm_en, dm_wr, addr, wdata         core request
//   end_process                       blocks core requests while high
//   dm_out, status                    core read data and handshake (READY/BUSY/DONE/ERR)
//   host_en, host_wr, host_addr, host_wdata  host request
//   host_rdata, host_ack              host read data and one-cycle completion pulse
module dm_port_ctrl
  import dm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 10
) (
  input  logic              clock,
  input  logic              rst_r,
  input  logic              dm_en,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              end_process,
  output logic [DATA_W-1:0] dm_out,
  output logic [1:0]        status,
  input  logic              host_en,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack
);
  state_t            state;
  logic              req_core;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [MEM_AW-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] ram_q;
  logic              lat_wr;
  logic              lat_core;
  logic              lat_oor;
  assign req_core = dm_en && !end_process;
  assign accept   = (state == IDLE || state == ERR) && (req_core || host_en);
  assign sel_addr = req_core ? addr : host_addr;
  // The array is read speculatively at accept so the word is ready at the next edge;
  // writes commit one edge later from the latched request.
  dm_sram #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) u_sram (
    .clock (clock),
    .we    (state == ACCESS && lat_wr && !lat_oor),
    .waddr (lat_addr),
    .wdata (lat_data),
    .re    (accept),
    .raddr (sel_addr[MEM_AW-1:0]),
    .rdata (ram_q)
  );
  always_ff @(posedge clock or negedge rst_r) begin
    if (!rst_r) begin
      state      <= IDLE;
      status     <= ST_READY;
      dm_out     <= '0;
      host_rdata <= '0;
      host_ack   <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_wr     <= 1'b0;
      lat_core   <= 1'b0;
      lat_oor    <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        IDLE, ERR: if (accept) begin
          state    <= ACCESS;
          status   <= ST_BUSY;
          lat_core <= req_core;
          lat_wr   <= req_core ? dm_wr : host_wr;
          lat_addr <= sel_addr[MEM_AW-1:0];
          lat_data <= req_core ? wdata : host_wdata;
          lat_oor  <= |sel_addr[ADDR_W-1:MEM_AW];
        end
        ACCESS: begin
          state    <= lat_oor ? ERR : DONE;
          status   <= lat_oor ? ST_ERR : ST_DONE;
          host_ack <= !lat_core;
          if (lat_oor) begin
            if (!lat_core) host_rdata <= '0;
          end else if (!lat_wr) begin
            if (lat_core) dm_out <= ram_q;
            else host_rdata <= ram_q;
          end
        end
        DONE: begin
          state  <= IDLE;
          status <= ST_READY;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dm_port_ctrl.sv
// tb_dm_port_ctrl: randomized self-checking bench with a transaction-level memory model
module tb_dm_port_ctrl;
  logic        clock = 1'b0;
  logic        rst_r = 1'b0;
  logic        dm_en = 1'b0, dm_wr = 1'b0, end_process = 1'b0;
  logic [15:0] addr = '0, host_addr = '0;
  logic [7:0]  wdata = '0, host_wdata = '0;
  logic        host_en = 1'b0, host_wr = 1'b0;
  logic [7:0]  dm_out, host_rdata;
  logic [1:0]  status;
  logic        host_ack;

  dm_port_ctrl dut (
    .clock(clock), .rst_r(rst_r), .dm_en(dm_en), .dm_wr(dm_wr), .addr(addr), .wdata(wdata),
    .end_process(end_process), .dm_out(dm_out), .status(status), .host_en(host_en),
    .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] ref_mem [1024];
  logic [7:0] ref_dm = '0;
  logic [7:0] ref_hr = '0;
  logic [1:0] ref_rest = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic txn(input bit c_en, input bit c_wr, input logic [15:0] c_a, input logic [7:0] c_d,
                     input bit ep, input bit h_en, input bit h_wr, input logic [15:0] h_a,
                     input logic [7:0] h_d, input bit hold);
    bit core, host, wr, oor;
    logic [15:0] a;
    logic [7:0] d;
    dm_en = c_en; dm_wr = c_wr; addr = c_a; wdata = c_d; end_process = ep;
    host_en = h_en; host_wr = h_wr; host_addr = h_a; host_wdata = h_d;
    core = c_en && !ep;
    host = !core && h_en;
    step();
    if (!core && !host) begin
      check("idle_status", status, ref_rest);
      check("idle_ack", host_ack, 0);
    end else begin
      wr  = core ? c_wr : h_wr;
      a   = core ? c_a : h_a;
      d   = core ? c_d : h_d;
      oor = a >= 16'd1024;
      check("e0_status", status, 2'b01);
      check("e0_ack", host_ack, 0);
      if (!hold) begin
        dm_en = 1'b0; host_en = 1'b0;
      end else begin
        // rival traffic during the transaction must be ignored
        end_process = $urandom_range(0, 1);
        host_en = 1'b1;
      end
      step();
      if (oor) begin
        if (host) ref_hr = '0;
      end else if (wr) ref_mem[a[9:0]] = d;
      else if (core) ref_dm = ref_mem[a[9:0]];
      else ref_hr = ref_mem[a[9:0]];
      check("e1_status", status, oor ? 2'b11 : 2'b10);
      check("e1_ack", host_ack, host);
      check("e1_dm_out", dm_out, ref_dm);
      if (host) check("e1_host_rdata", host_rdata, ref_hr);
      step();
      ref_rest = oor ? 2'b11 : 2'b00;
      check("e2_status", status, ref_rest);
      check("e2_ack", host_ack, 0);
      check("e2_dm_out", dm_out, ref_dm);
    end
    if (!hold) begin
      dm_en = 1'b0; host_en = 1'b0; end_process = 1'b0;
    end
  endtask

  function automatic logic [15:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 4) return 16'($urandom_range(0, 63));
    if (r < 8) return 16'($urandom_range(960, 1023));
    return 16'($urandom_range(1024, 65535));
  endfunction

  initial begin
    #12 rst_r = 1'b1;
    #1;
    check("rst_status", status, 2'b00);
    check("rst_dm_out", dm_out, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_ack", host_ack, 0);
    // preload the windows the random phase uses
    for (int i = 0; i < 64; i++) txn(0, 0, 0, 0, 0, 1, 1, 16'(i), 8'(i * 7 + 3), 0);
    for (int i = 960; i < 1024; i++) txn(0, 0, 0, 0, 0, 1, 1, 16'(i), 8'(i * 5 + 1), 0);
    // reset during ACCESS of a write drops it
    dm_en = 1; dm_wr = 1; addr = 16'h010; wdata = 8'hA5;
    step();
    check("t1_e0_status", status, 2'b01);
    dm_en = 0;
    #2 rst_r = 1'b0;
    #2 rst_r = 1'b1;
    ref_dm = '0; ref_hr = '0; ref_rest = 2'b00;
    check("t1_status", status, 2'b00);
    check("t1_dm_out", dm_out, 0);
    check("t1_host_rdata", host_rdata, 0);
    txn(1, 0, 16'h010, 0, 0, 0, 0, 0, 0, 0);
    check("t1_not_committed", dm_out == 8'hA5, 0);
    // write then read back
    txn(1, 1, 16'h005, 8'h3C, 0, 0, 0, 0, 0, 0);
    txn(1, 0, 16'h005, 0, 0, 0, 0, 0, 0, 0);
    check("t2_dm_out", dm_out, 8'h3C);
    // out of range, ERR held, then a valid request recovers
    txn(1, 0, 16'h0400, 0, 0, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(1, 0, 16'h3FF, 0, 0, 0, 0, 0, 0, 0);
    // simultaneous: core first, host re-issues
    txn(1, 1, 16'h020, 8'h77, 0, 1, 0, 16'h020, 0, 0);
    txn(0, 0, 0, 0, 0, 1, 0, 16'h020, 0, 0);
    check("t4_host_rdata", host_rdata, 8'h77);
    // end_process blocks the core
    txn(1, 0, 16'h006, 0, 1, 1, 0, 16'h005, 0, 0);
    check("t5_host_rdata", host_rdata, 8'h3C);
    // dm_en held high: one transaction per accept, back to back
    for (int i = 0; i < 3; i++) txn(1, 0, 16'(i), 0, 0, 0, 0, 0, 0, 1);
    dm_en = 0; host_en = 0; end_process = 0;
    // random traffic
    for (int i = 0; i < 300; i++)
      txn($urandom_range(0, 3) != 0, $urandom_range(0, 1), rand_addr(), 8'($urandom),
          $urandom_range(0, 4) == 0, $urandom_range(0, 1), $urandom_range(0, 1), rand_addr(),
          8'($urandom), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
